// File: rtl/icache_sa_pkg.sv
// icache_sa_pkg: shared cache defaults, NOP encoding and refill FSM states
package icache_sa_pkg;
    localparam int ICACHE_XLEN = 32;
    localparam int ICACHE_WAYS = 2;
    localparam int ICACHE_SETS = 64;
    localparam int ICACHE_LINE_WORDS = 4;
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REFILL = 2'd1, S_INSTALL = 2'd2} state_t;
endpackage

// File: rtl/icache_sa_if.sv
// icache_sa_if: fetch-side lookup and refill-memory handshake of the instruction cache
interface icache_sa_if
    import icache_sa_pkg::*;
#(parameter int XLEN = ICACHE_XLEN);
    logic [XLEN-1:0] pc, instruction, mem_addr, mem_data;
    logic fetch_en, invalidate, ready, hit, miss, mem_req, mem_ack;
    modport slave (input pc, fetch_en, invalidate, mem_ack, mem_data,
                   output instruction, ready, hit, miss, mem_req, mem_addr);
    modport master (output pc, fetch_en, invalidate, mem_ack, mem_data,
                    input instruction, ready, hit, miss, mem_req, mem_addr);
endinterface

// File: rtl/icache_sa_repl.sv
// icache_repl: per-set round-robin pointers; lowest invalid way overrides the pointer as victim
module icache_repl
    import icache_sa_pkg::*;
#(
    parameter int WAYS = ICACHE_WAYS,
    parameter int SETS = ICACHE_SETS,
    localparam int VW = WAYS > 1 ? $clog2(WAYS) : 1,
    localparam int IW = $clog2(SETS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] i_idx,
    input  logic [WAYS-1:0] i_valid,
    input  logic          i_upd,
    input  logic [IW-1:0] i_upd_idx,
    input  logic [VW-1:0] i_upd_way,
    output logic [VW-1:0] o_victim
);
    logic [VW-1:0] r_ptr [SETS];

    always_ff @(posedge clk) begin
        if (reset) for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
        else if (i_upd) r_ptr[i_upd_idx] <= VW'((int'(i_upd_way) + 1) % WAYS);
    end

    always_comb begin
        o_victim = r_ptr[i_idx];
        for (int w = WAYS - 1; w >= 0; w--) if (!i_valid[w]) o_victim = VW'(w);
    end
endmodule

// File: rtl/icache_sa.sv
// icache_sa: parametrised set-associative instruction cache with multi-beat line refill,
// round-robin replacement and whole-cache invalidate
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int XLEN = ICACHE_XLEN,
    parameter int WAYS = ICACHE_WAYS,
    parameter int SETS = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input logic clk,
    input logic reset,
    icache_sa_if.slave bus
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int BW = OW > 0 ? OW : 1;
    localparam int IW = $clog2(SETS);
    localparam int VW = WAYS > 1 ? $clog2(WAYS) : 1;
    localparam int TW = XLEN - 2 - OW - IW;

    state_t r_state, w_next;
    logic [BW-1:0] r_beat;
    logic [XLEN-1:0] r_base;
    logic [IW-1:0] r_idx;
    logic [TW-1:0] r_tag;
    logic [VW-1:0] r_victim, w_victim;
    logic r_kill;
    logic [XLEN-1:0] r_buf [LINE_WORDS];
    logic [WAYS-1:0] r_valid [SETS];
    logic [TW-1:0] r_tags [WAYS][SETS];
    logic [XLEN-1:0] r_data [WAYS][SETS][LINE_WORDS];

    logic [BW-1:0] w_off;
    logic [IW-1:0] w_idx;
    logic [TW-1:0] w_tag;
    logic [WAYS-1:0] w_match;
    logic [XLEN-1:0] w_word;
    logic w_lookup, w_hit, w_miss, w_ack, w_last, w_install;

    assign w_off = BW'((bus.pc >> 2) & XLEN'(LINE_WORDS - 1));
    assign w_idx = IW'(bus.pc >> (OW + 2));
    assign w_tag = TW'(bus.pc >> (OW + IW + 2));

    always_comb begin
        w_match = '0;
        w_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_match[w] = r_valid[w_idx][w] && r_tags[w][w_idx] == w_tag;
            w_word |= w_match[w] ? r_data[w][w_idx][w_off] : '0;
        end
    end

    assign w_lookup = !reset && r_state == S_IDLE && bus.fetch_en;
    assign w_hit = w_lookup && !bus.invalidate && |w_match;
    assign w_miss = w_lookup && !w_hit;
    assign w_ack = r_state == S_REFILL && bus.mem_ack;
    assign w_last = r_beat == BW'(LINE_WORDS - 1);
    // an invalidate seen at any point of the refill, or during install, drops the line
    assign w_install = r_state == S_INSTALL && !r_kill && !bus.invalidate;

    assign bus.hit = w_hit;
    assign bus.miss = w_miss;
    assign bus.ready = reset ? !bus.fetch_en : r_state == S_IDLE && (!bus.fetch_en || w_hit);
    assign bus.instruction = w_hit ? w_word : XLEN'(NOP_INSTRUCTION);
    assign bus.mem_req = !reset && r_state == S_REFILL;
    assign bus.mem_addr = bus.mem_req ? r_base + (XLEN'(r_beat) << 2) : '0;

    always_comb begin
        w_next = r_state;
        if (w_miss) w_next = S_REFILL;
        if (w_ack && w_last) w_next = S_INSTALL;
        if (r_state == S_INSTALL) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_beat <= '0;
            r_kill <= 1'b0;
            for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss) begin
                r_base <= bus.pc & ~XLEN'(LINE_WORDS * 4 - 1);
                r_idx <= w_idx;
                r_tag <= w_tag;
                r_victim <= w_victim;
                r_kill <= 1'b0;
            end
            if (w_ack) begin
                r_buf[r_beat] <= bus.mem_data;
                r_beat <= w_last ? '0 : r_beat + BW'(1);
            end
            if (r_state == S_REFILL && bus.invalidate) r_kill <= 1'b1;
            if (w_install) begin
                r_valid[r_idx][r_victim] <= 1'b1;
                r_tags[r_victim][r_idx] <= r_tag;
                for (int k = 0; k < LINE_WORDS; k++) r_data[r_victim][r_idx][k] <= r_buf[k];
            end
            if (bus.invalidate) for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
        end
    end

    always_ff @(posedge clk) if (!reset) assert ($onehot0(w_match));

    icache_repl #(.WAYS(WAYS), .SETS(SETS)) u_repl (
        .clk(clk),
        .reset(reset),
        .i_idx(w_idx),
        .i_valid(r_valid[w_idx]),
        .i_upd(w_install),
        .i_upd_idx(r_idx),
        .i_upd_way(r_victim),
        .o_victim(w_victim)
    );
endmodule
